// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address width, reset PC, sequential increment
// and the PC sequencer state encoding (reused by the hazard unit and trace monitor).
package cpu_pkg;

   localparam int unsigned PcXlen    = 32;
   localparam logic [31:0] PcResetPc = 32'h0000_0000;
   localparam int unsigned PcInc     = 4;

   typedef enum logic [1:0] {
      PcBoot  = 2'd0,
      PcFetch = 2'd1,
      PcPend  = 2'd2,
      PcStall = 2'd3
   } pc_state_e;

   // Instruction targets must be word aligned; low bits set means a misaligned redirect.
   function automatic logic misaligned(input logic [1:0] low);
      return low != 2'b00;
   endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds one pending redirect target while the fetch request it arrived with is still
// waiting for acceptance. First redirect wins; younger ones are wrong-path and dropped.
// Ports:
//   clk, rst_n  clock, async active-low reset (discards any pending target)
//   set_i       capture data_i if nothing is pending
//   clr_i       pending target committed to the PC this cycle
//   data_i      redirect target
//   valid_o     a target is pending
//   data_o      pending target
module redirect_latch #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_i,
   input  logic             clr_i,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [Width-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (set_i && !valid_q) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer behind the branch unit. Owns the PC, drives the
// instruction-fetch valid/ready handshake and pulses flush (and misalign) for one
// cycle when a redirect commits to the PC.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   taken, jump  redirect request from the branch unit; target is its address
//   stall        downstream cannot take more instructions
//   fetch_ready  imem accepts the request this cycle
//   fetch_valid  request valid; fetch_addr is the current PC
//   pc_plus4     fetch_addr + INC (link value)
//   flush        one-cycle kill of wrong-path fetch/decode
//   misalign     accompanies flush when the redirect target was not word aligned
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned      XLEN     = PcXlen,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(PcResetPc),
   parameter int unsigned      INC      = PcInc
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            taken,
   input  logic            jump,
   input  logic [XLEN-1:0] target,
   input  logic            stall,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_addr,
   output logic [XLEN-1:0] pc_plus4,
   output logic            flush,
   output logic            misalign
);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            flush_q, flush_d;
   logic            misalign_q, misalign_d;

   logic            redirect, handshake, valid_int;
   logic            pend_set, pend_clr, pend_valid;
   logic [XLEN-1:0] pend_target;

   assign redirect  = taken | jump;
   assign valid_int = (state_q == PcFetch) || (state_q == PcPend);
   assign handshake = valid_int & fetch_ready;

   redirect_latch #(
      .Width (XLEN)
   ) u_redirect_latch (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_i   (pend_set),
      .clr_i   (pend_clr),
      .data_i  (target),
      .valid_o (pend_valid),
      .data_o  (pend_target)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      flush_d    = 1'b0;
      misalign_d = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      unique case (state_q)
         PcBoot: state_d = PcFetch;
         PcFetch: begin
            if (handshake) begin
               if (redirect) begin
                  pc_d       = {target[XLEN-1:2], 2'b00};
                  flush_d    = 1'b1;
                  misalign_d = misaligned(target[1:0]);
               end else begin
                  pc_d = pc_q + XLEN'(INC);
               end
               state_d = stall ? PcStall : PcFetch;
            end else if (redirect) begin
               // Request outstanding: address must stay stable, so park the target.
               pend_set = 1'b1;
               state_d  = PcPend;
            end
         end
         PcPend: begin
            // New redirects are younger wrong-path ones and are ignored here.
            if (handshake) begin
               pend_clr = 1'b1;
               if (pend_valid) begin
                  pc_d       = {pend_target[XLEN-1:2], 2'b00};
                  flush_d    = 1'b1;
                  misalign_d = misaligned(pend_target[1:0]);
               end else begin
                  pc_d = pc_q + XLEN'(INC);
               end
               state_d = stall ? PcStall : PcFetch;
            end
         end
         PcStall: begin
            // No request is outstanding, so a redirect can land on the PC at once.
            if (redirect) begin
               pc_d       = {target[XLEN-1:2], 2'b00};
               flush_d    = 1'b1;
               misalign_d = misaligned(target[1:0]);
            end
            if (!stall) state_d = PcFetch;
         end
         default: state_d = PcBoot;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PcBoot;
         pc_q       <= RESET_PC;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end

   assign fetch_valid = valid_int;
   assign fetch_addr  = pc_q;
   assign pc_plus4    = pc_q + XLEN'(INC);
   assign flush       = flush_q;
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot sequence, redirect during handshake, pending
// redirect with first-wins, stall with redirect, misaligned target, PC wrap and
// reset while a redirect is pending.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        taken = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] target = '0;
   logic        stall = 1'b0;
   logic        fetch_ready = 1'b1;

   logic        fetch_valid, flush, misalign;
   logic [31:0] fetch_addr, pc_plus4;
   logic        b_fetch_valid, b_flush, b_misalign;
   logic [31:0] b_fetch_addr, b_pc_plus4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_sequencer u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .taken       (taken),
      .jump        (jump),
      .target      (target),
      .stall       (stall),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_addr  (fetch_addr),
      .pc_plus4    (pc_plus4),
      .flush       (flush),
      .misalign    (misalign)
   );

   pc_sequencer #(
      .RESET_PC (32'hFFFF_FFFC)
   ) u_dut_wrap (
      .clk         (clk),
      .rst_n       (rst_n),
      .taken       (taken),
      .jump        (jump),
      .target      (target),
      .stall       (stall),
      .fetch_ready (fetch_ready),
      .fetch_valid (b_fetch_valid),
      .fetch_addr  (b_fetch_addr),
      .pc_plus4    (b_pc_plus4),
      .flush       (b_flush),
      .misalign    (b_misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check valid/addr/pc_plus4/flush/misalign of the main DUT in one go.
   task automatic chk_a(input string tag, input logic v, input logic [31:0] a,
                        input logic f, input logic m);
      chk({tag, ".valid"}, 32'(fetch_valid), 32'(v));
      chk({tag, ".addr"}, fetch_addr, a);
      chk({tag, ".plus4"}, pc_plus4, a + 32'd4);
      chk({tag, ".flush"}, 32'(flush), 32'(f));
      chk({tag, ".misalign"}, 32'(misalign), 32'(m));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #1;
      chk_a("rst", 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      // 1: boot cycle then sequential fetch
      chk_a("boot", 1'b0, 32'h0, 1'b0, 1'b0);
      step(); chk_a("seq0", 1'b1, 32'h0, 1'b0, 1'b0);
      step(); chk_a("seq4", 1'b1, 32'h4, 1'b0, 1'b0);
      step(); chk_a("seq8", 1'b1, 32'h8, 1'b0, 1'b0);
      step(); chk_a("seqc", 1'b1, 32'hC, 1'b0, 1'b0);
      step(); chk_a("seq10", 1'b1, 32'h10, 1'b0, 1'b0);
      // 2: taken during handshake
      taken = 1'b1; target = 32'h100;
      step(); chk_a("br100", 1'b1, 32'h100, 1'b1, 1'b0);
      taken = 1'b0;
      step(); chk_a("br104", 1'b1, 32'h104, 1'b0, 1'b0);
      taken = 1'b1; target = 32'h20;
      step(); chk_a("br20", 1'b1, 32'h20, 1'b1, 1'b0);
      // 3: redirect while not ready, younger redirect ignored
      taken = 1'b0; fetch_ready = 1'b0; jump = 1'b1; target = 32'h200;
      step(); chk_a("pend1", 1'b1, 32'h20, 1'b0, 1'b0);
      jump = 1'b0; taken = 1'b1; target = 32'h300;
      step(); chk_a("pend2", 1'b1, 32'h20, 1'b0, 1'b0);
      taken = 1'b0;
      step(); chk_a("pend3", 1'b1, 32'h20, 1'b0, 1'b0);
      step(); chk_a("pend4", 1'b1, 32'h20, 1'b0, 1'b0);
      fetch_ready = 1'b1;
      step(); chk_a("pend200", 1'b1, 32'h200, 1'b1, 1'b0);
      step(); chk_a("pend204", 1'b1, 32'h204, 1'b0, 1'b0);
      // 4: stall, then redirect during stall
      taken = 1'b1; target = 32'h40;
      step(); chk_a("br40", 1'b1, 32'h40, 1'b1, 1'b0);
      taken = 1'b0; stall = 1'b1;
      step(); chk_a("stl44a", 1'b0, 32'h44, 1'b0, 1'b0);
      step(); chk_a("stl44b", 1'b0, 32'h44, 1'b0, 1'b0);
      stall = 1'b0;
      step(); chk_a("res44", 1'b1, 32'h44, 1'b0, 1'b0);
      stall = 1'b1;
      step(); chk_a("stl48", 1'b0, 32'h48, 1'b0, 1'b0);
      taken = 1'b1; target = 32'h80;
      step(); chk_a("stlbr80", 1'b0, 32'h80, 1'b1, 1'b0);
      taken = 1'b0;
      step(); chk_a("stl80", 1'b0, 32'h80, 1'b0, 1'b0);
      stall = 1'b0;
      step(); chk_a("res80", 1'b1, 32'h80, 1'b0, 1'b0);
      step(); chk_a("seq84", 1'b1, 32'h84, 1'b0, 1'b0);
      // 5: misaligned target
      taken = 1'b1; target = 32'h102;
      step(); chk_a("mis100", 1'b1, 32'h100, 1'b1, 1'b1);
      taken = 1'b0;
      step(); chk_a("mis104", 1'b1, 32'h104, 1'b0, 1'b0);
      // 6: reset asserted while a redirect is pending
      fetch_ready = 1'b0; jump = 1'b1; target = 32'h500;
      step(); chk_a("pend500", 1'b1, 32'h104, 1'b0, 1'b0);
      jump = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_a("asyncrst", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap.rst.addr", b_fetch_addr, 32'hFFFF_FFFC);
      chk("wrap.rst.plus4", b_pc_plus4, 32'h0);
      step();
      rst_n = 1'b1; fetch_ready = 1'b1;
      chk_a("reboot", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap.boot.valid", 32'(b_fetch_valid), 32'h0);
      step(); chk_a("restart0", 1'b1, 32'h0, 1'b0, 1'b0);
      chk("wrap.first.addr", b_fetch_addr, 32'hFFFF_FFFC);
      chk("wrap.first.valid", 32'(b_fetch_valid), 32'h1);
      step(); chk_a("restart4", 1'b1, 32'h4, 1'b0, 1'b0);
      chk("wrap.second.addr", b_fetch_addr, 32'h0);
      chk("wrap.second.flush", 32'(b_flush), 32'h0);
      chk("wrap.second.misalign", 32'(b_misalign), 32'h0);
      step(); chk_a("restart8", 1'b1, 32'h8, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
